// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer driving a clear/load/increment PC counter.
// Optional memory-ack timeout enabled by defining FETCH_TIMEOUT_EN.
module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] pc_q,
  output logic        pc_reset,
  output logic        pc_load,
  output logic        pc_inc,
  output logic [31:0] pc_din,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  output logic        br_ready,
  input  logic        halt,
  output logic        halted,
  output logic [31:0] fetch_count,
  output logic        fetch_err
);

  typedef enum logic [1:0] {INIT, REQ, VALID, HALTED} state_t;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t      state_q;
  logic        imem_req_q, instr_valid_q, halted_q, fetch_err_q;
  logic [31:0] instr_q, instr_pc_q, fetch_count_q;

`ifdef FETCH_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wait_q;
`endif

  // Counter control is decoded from the current state so the PC moves on
  // the same edge that the state advances.
  always_comb begin
    pc_load  = 1'b0;
    pc_inc   = 1'b0;
    pc_din   = 32'h0;
    br_ready = 1'b0;
    if (reset_n) begin
      case (state_q)
        INIT: begin
          pc_load = 1'b1;
          pc_din  = RESET_VECTOR;
        end
        REQ: pc_inc = imem_ack;
        VALID, HALTED: begin
          br_ready = 1'b1;
          if (br_valid) begin
            pc_load = 1'b1;
            pc_din  = br_target;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= INIT;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      fetch_err_q   <= 1'b0;
      instr_q       <= 32'h0;
      instr_pc_q    <= 32'h0;
      fetch_count_q <= 32'h0;
`ifdef FETCH_TIMEOUT_EN
      wait_q        <= '0;
`endif
    end else begin
      case (state_q)
        INIT: begin
          state_q    <= REQ;
          imem_req_q <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
          wait_q     <= '0;
`endif
        end
        REQ: begin
          if (imem_ack) begin
            state_q       <= VALID;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b1;
            instr_q       <= imem_rdata;
            instr_pc_q    <= pc_q;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (wait_q == WW'(TIMEOUT_CYCLES - 1)) begin
            state_q     <= HALTED;
            imem_req_q  <= 1'b0;
            halted_q    <= 1'b1;
            fetch_err_q <= 1'b1;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
`endif
        end
        VALID: begin
          // A redirect discards the held instruction without counting it.
          if (br_valid) begin
            state_q       <= REQ;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
            wait_q        <= '0;
`endif
          end else if (instr_ready) begin
            instr_valid_q <= 1'b0;
            fetch_count_q <= fetch_count_q + 32'd1;
            if (halt) begin
              state_q  <= HALTED;
              halted_q <= 1'b1;
            end else begin
              state_q    <= REQ;
              imem_req_q <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
              wait_q     <= '0;
`endif
            end
          end
        end
        HALTED: begin
          if (br_valid) begin
            state_q    <= REQ;
            halted_q   <= 1'b0;
            imem_req_q <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
            wait_q     <= '0;
`endif
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

  assign pc_reset    = ~reset_n;
  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_req_q ? pc_q : 32'h0;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign halted      = halted_q;
  assign fetch_count = fetch_count_q;
  assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus a randomized run
// against an address-stream reference model; models the PC counter.
module tb_fetch_sequencer;
  localparam logic [31:0] RV = 32'h100;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] pc_q;
  logic        pc_reset, pc_load, pc_inc;
  logic [31:0] pc_din;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr, instr_pc;
  logic        instr_ready, br_valid;
  logic [31:0] br_target;
  logic        br_ready, halt, halted;
  logic [31:0] fetch_count;
  logic        fetch_err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_count;

  always #5 clk = ~clk;

  fetch_sequencer #(.RESET_VECTOR(RV), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset_n(reset_n), .pc_q(pc_q), .pc_reset(pc_reset),
    .pc_load(pc_load), .pc_inc(pc_inc), .pc_din(pc_din),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr(instr),
    .instr_pc(instr_pc), .instr_ready(instr_ready), .br_valid(br_valid),
    .br_target(br_target), .br_ready(br_ready), .halt(halt), .halted(halted),
    .fetch_count(fetch_count), .fetch_err(fetch_err)
  );

  // PC counter: clear > load > increment
  always @(posedge clk) begin
    if (pc_reset)     pc_q <= 32'h0;
    else if (pc_load) pc_q <= pc_din;
    else if (pc_inc)  pc_q <= pc_q + 32'd1;
  end

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    n_checks++;
    if ({imem_req, instr_valid, halted, fetch_err, pc_load, pc_inc, br_ready, pc_reset} !== 8'b0000_0001) begin
      n_fail++;
      $display("FAIL %s_flags: got %b, expected 00000001", tag,
        {imem_req, instr_valid, halted, fetch_err, pc_load, pc_inc, br_ready, pc_reset});
    end
    n_checks++;
    if ({fetch_count, instr, instr_pc, imem_addr} !== 128'h0) begin
      n_fail++;
      $display("FAIL %s_regs: got count=%h instr=%h ipc=%h addr=%h, expected all 0", tag,
        fetch_count, instr, instr_pc, imem_addr);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
    br_valid = 1'b0; br_target = 32'h0; halt = 1'b0;
    tick(); tick(); tick();
    check_reset_outputs("reset");
    reset_n = 1'b1;
    #1;
    n_checks++;
    if ({pc_load, pc_inc, pc_reset} !== 3'b100 || pc_din !== RV) begin
      n_fail++;
      $display("FAIL init_load: got load/inc/rst=%b din=%h, expected 100 din=%h",
        {pc_load, pc_inc, pc_reset}, pc_din, RV);
    end
    tick();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== RV || pc_q !== RV) begin
      n_fail++;
      $display("FAIL first_req: got req=%b addr=%h pc=%h, expected 1 %h", imem_req, imem_addr, pc_q, RV);
    end
    exp_count = 32'h0;
  endtask

  task automatic test_stream();
    instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== RV + 32'(i)) begin
        n_fail++;
        $display("FAIL stream_addr%0d: got req=%b addr=%h, expected 1 %h", i, imem_req, imem_addr, RV + 32'(i));
      end
      imem_ack = 1'b1; imem_rdata = mem(imem_addr);
      #1;
      n_checks++;
      if ({pc_inc, pc_load} !== 2'b10) begin
        n_fail++;
        $display("FAIL stream_inc%0d: got inc/load=%b, expected 10", i, {pc_inc, pc_load});
      end
      tick();
      imem_ack = 1'b0; imem_rdata = 32'h0;
      n_checks++;
      if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== mem(RV + 32'(i)) ||
          instr_pc !== RV + 32'(i) || pc_q !== RV + 32'(i) + 32'd1) begin
        n_fail++;
        $display("FAIL stream_valid%0d: got v=%b req=%b instr=%h ipc=%h pc=%h, expected 1 0 %h %h %h", i,
          instr_valid, imem_req, instr, instr_pc, pc_q, mem(RV + 32'(i)), RV + 32'(i), RV + 32'(i) + 32'd1);
      end
      tick();
      exp_count++;
      n_checks++;
      if (fetch_count !== exp_count || imem_req !== 1'b1 || instr_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL stream_accept%0d: got count=%0d req=%b v=%b, expected %0d 1 0", i,
          fetch_count, imem_req, instr_valid, exp_count);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] a;
    a = imem_addr;
    instr_ready = 1'b0;
    imem_ack = 1'b1; imem_rdata = mem(a);
    tick();
    imem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== mem(a) || instr_pc !== a ||
          pc_q !== a + 32'd1 || fetch_count !== exp_count) begin
        n_fail++;
        $display("FAIL stall%0d: got v=%b req=%b instr=%h ipc=%h pc=%h cnt=%0d, expected 1 0 %h %h %h %0d", i,
          instr_valid, imem_req, instr, instr_pc, pc_q, fetch_count, mem(a), a, a + 32'd1, exp_count);
      end
    end
    instr_ready = 1'b1;
    tick();
    exp_count++;
    instr_ready = 1'b0;
  endtask

  task automatic test_branch();
    imem_ack = 1'b1; imem_rdata = mem(imem_addr);
    tick();
    imem_ack = 1'b0;
    br_valid = 1'b1; br_target = 32'h2000; instr_ready = 1'b1; halt = 1'b1;
    #1;
    n_checks++;
    if ({br_ready, pc_load, pc_inc} !== 3'b110 || pc_din !== 32'h2000) begin
      n_fail++;
      $display("FAIL branch_ctl: got rdy/load/inc=%b din=%h, expected 110 00002000", {br_ready, pc_load, pc_inc}, pc_din);
    end
    tick();
    br_valid = 1'b0; instr_ready = 1'b0; halt = 1'b0;
    n_checks++;
    if (fetch_count !== exp_count || imem_req !== 1'b1 || imem_addr !== 32'h2000 ||
        instr_valid !== 1'b0 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL branch_redirect: got cnt=%0d req=%b addr=%h v=%b h=%b, expected %0d 1 00002000 0 0",
        fetch_count, imem_req, imem_addr, instr_valid, halted, exp_count);
    end
  endtask

  task automatic test_halt();
    imem_ack = 1'b1; imem_rdata = mem(imem_addr);
    tick();
    imem_ack = 1'b0;
    halt = 1'b1; instr_ready = 1'b1;
    tick();
    exp_count++;
    halt = 1'b0; instr_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if ({halted, imem_req, instr_valid} !== 3'b100 || fetch_count !== exp_count) begin
        n_fail++;
        $display("FAIL halted%0d: got h/req/v=%b cnt=%0d, expected 100 %0d", i, {halted, imem_req, instr_valid},
          fetch_count, exp_count);
      end
      tick();
    end
    br_valid = 1'b1; br_target = 32'h40;
    #1;
    n_checks++;
    if ({br_ready, pc_load} !== 2'b11 || pc_din !== 32'h40) begin
      n_fail++;
      $display("FAIL halt_br_ctl: got rdy/load=%b din=%h, expected 11 00000040", {br_ready, pc_load}, pc_din);
    end
    tick();
    br_valid = 1'b0;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h40 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_resume: got req=%b addr=%h h=%b, expected 1 00000040 0", imem_req, imem_addr, halted);
    end
  endtask

  task automatic test_reset_mid();
    tick(); tick();
    reset_n = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    check_reset_outputs("midreset");
    reset_n = 1'b1;
    #1;
    n_checks++;
    if ({pc_load, pc_inc} !== 2'b10 || pc_din !== RV) begin
      n_fail++;
      $display("FAIL late_ack_init: got load/inc=%b din=%h, expected 10 %h", {pc_load, pc_inc}, pc_din, RV);
    end
    tick();
    imem_ack = 1'b0;
    exp_count = 32'h0;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== RV || instr_valid !== 1'b0 || instr !== 32'h0) begin
      n_fail++;
      $display("FAIL restart: got req=%b addr=%h v=%b instr=%h, expected 1 %h 0 0", imem_req, imem_addr,
        instr_valid, instr, RV);
    end
  endtask

  task automatic test_timeout();
`ifdef FETCH_TIMEOUT_EN
    for (int i = 0; i < 7; i++) begin
      tick();
      n_checks++;
      if (imem_req !== 1'b1 || fetch_err !== 1'b0 || halted !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout_wait%0d: got req=%b err=%b h=%b, expected 1 0 0", i, imem_req, fetch_err, halted);
      end
    end
    tick();
    n_checks++;
    if ({fetch_err, halted, imem_req} !== 3'b110) begin
      n_fail++;
      $display("FAIL timeout_hit: got err/h/req=%b, expected 110", {fetch_err, halted, imem_req});
    end
    br_valid = 1'b1; br_target = 32'h2000;
    tick();
    br_valid = 1'b0;
    n_checks++;
    if ({fetch_err, halted, imem_req} !== 3'b101 || imem_addr !== 32'h2000) begin
      n_fail++;
      $display("FAIL timeout_redirect: got err/h/req=%b addr=%h, expected 101 00002000",
        {fetch_err, halted, imem_req}, imem_addr);
    end
`else
    for (int i = 0; i < 20; i++) tick();
    n_checks++;
    if ({imem_req, fetch_err, halted} !== 3'b100 || imem_addr !== RV) begin
      n_fail++;
      $display("FAIL no_timeout: got req/err/h=%b addr=%h, expected 100 %h", {imem_req, fetch_err, halted},
        imem_addr, RV);
    end
`endif
  endtask

  // Model: the stream of fetch addresses, which instruction is presented,
  // and how many were accepted; phase 0=fetching, 1=presenting, 2=halted.
  task automatic test_random();
    logic [31:0] exp_addr, exp_ipc, br_tgt;
    logic        br_pend;
    int          phase, wcnt;
    reset_n = 1'b0; imem_ack = 1'b0; br_valid = 1'b0; halt = 1'b0; instr_ready = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    exp_addr = RV; exp_ipc = 32'h0; exp_count = 32'h0;
    phase = 0; wcnt = 0; br_pend = 1'b0; br_tgt = 32'h0;
    for (int c = 0; c < 2000; c++) begin
      if (!br_pend && $urandom_range(0, 99) < 15) begin
        br_pend = 1'b1; br_tgt = $urandom;
      end
      br_valid = br_pend; br_target = br_tgt;
      instr_ready = ($urandom_range(0, 99) < 60);
      halt = ($urandom_range(0, 99) < 20);
      imem_ack = imem_req && (wcnt >= 4 || $urandom_range(0, 1) == 1);
      imem_rdata = imem_ack ? mem(imem_addr) : $urandom;
      #1;
      n_checks++;
      if (pc_load && pc_inc) begin
        n_fail++;
        $display("FAIL rnd_load_inc%0d: got load=1 inc=1, expected not both", c);
      end
      case (phase)
        0: begin
          n_checks++;
          if ({imem_req, instr_valid, halted, br_ready, pc_load} !== 5'b10000 || imem_addr !== exp_addr ||
              pc_inc !== imem_ack) begin
            n_fail++;
            $display("FAIL rnd_req%0d: got req/v/h/rdy/load=%b addr=%h inc=%b, expected 10000 %h %b", c,
              {imem_req, instr_valid, halted, br_ready, pc_load}, imem_addr, pc_inc, exp_addr, imem_ack);
          end
          if (imem_ack) begin
            exp_ipc = exp_addr; exp_addr = exp_addr + 32'd1; phase = 1; wcnt = 0;
          end else wcnt++;
        end
        1: begin
          n_checks++;
          if ({imem_req, instr_valid, halted, br_ready} !== 4'b0101 || instr !== mem(exp_ipc) ||
              instr_pc !== exp_ipc || pc_load !== br_valid || (br_valid && pc_din !== br_tgt)) begin
            n_fail++;
            $display("FAIL rnd_valid%0d: got req/v/h/rdy=%b instr=%h ipc=%h load=%b din=%h, expected 0101 %h %h %b %h",
              c, {imem_req, instr_valid, halted, br_ready}, instr, instr_pc, pc_load, pc_din,
              mem(exp_ipc), exp_ipc, br_valid, br_tgt);
          end
          if (br_valid) begin
            exp_addr = br_tgt; br_pend = 1'b0; phase = 0; wcnt = 0;
          end else if (instr_ready) begin
            exp_count++;
            phase = halt ? 2 : 0; wcnt = 0;
          end
        end
        default: begin
          n_checks++;
          if ({imem_req, instr_valid, halted, br_ready} !== 4'b0011 || pc_load !== br_valid) begin
            n_fail++;
            $display("FAIL rnd_halted%0d: got req/v/h/rdy=%b load=%b, expected 0011 %b", c,
              {imem_req, instr_valid, halted, br_ready}, pc_load, br_valid);
          end
          if (br_valid) begin
            exp_addr = br_tgt; br_pend = 1'b0; phase = 0; wcnt = 0;
          end
        end
      endcase
      tick();
      n_checks++;
      if (fetch_count !== exp_count || fetch_err !== 1'b0) begin
        n_fail++;
        $display("FAIL rnd_count%0d: got cnt=%0d err=%b, expected %0d 0", c, fetch_count, fetch_err, exp_count);
      end
    end
    imem_ack = 1'b0; br_valid = 1'b0; instr_ready = 1'b0; halt = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_branch();
    test_halt();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Controller for the 32-bit loadable program counter (clear/load/increment counter with priority clear > load > inc). Drives the counter's control inputs to sequence instruction fetch: loads the reset vector, issues request/acknowledge reads to instruction memory, steps the counter after each returned word, and redirects it on branches. Sits between the PC counter, instruction memory and the decode stage.

## Interface
- RESET_VECTOR, 32'h0000_0000, PC loaded after reset release
- TIMEOUT_CYCLES, 255, max wait cycles for imem_ack (used only with FETCH_TIMEOUT_EN)
- clk  input  1  system clock, all state on rising edge
- reset_n  input  1  synchronous, active-low reset
- pc_q  input  32  current counter value
- pc_reset  output  1  counter clear, = ~reset_n (combinational)
- pc_load  output  1  counter load strobe (combinational)
- pc_inc  output  1  counter increment strobe (combinational)
- pc_din  output  32  counter load value (combinational)
- imem_req  output  1  instruction read request
- imem_addr  output  32  read address, = pc_q while imem_req high
- imem_ack  input  1  read data valid this cycle
- imem_rdata  input  32  read data
- instr_valid  output  1  instruction available to decode
- instr  output  32  captured instruction
- instr_pc  output  32  address of instr
- instr_ready  input  1  decode accepts instr
- br_valid  input  1  branch/redirect request
- br_target  input  32  redirect address
- br_ready  output  1  redirect accepted this cycle (combinational)
- halt  input  1  stop fetching after current instruction is accepted
- halted  output  1  sequencer in HALTED
- fetch_count  output  32  accepted instructions, wraps at 2^32
- fetch_err  output  1  sticky memory timeout flag

## Operation
- States: INIT, REQ, VALID, HALTED.
- reset_n low: state INIT; instr, instr_pc, fetch_count, fetch_err = 0; pc_load, pc_inc, imem_req, instr_valid, br_ready, halted = 0; pc_reset = 1.
- INIT (first cycle with reset_n high): pc_load=1, pc_din=RESET_VECTOR; next REQ.
- REQ: imem_req=1, imem_addr=pc_q, held stable until ack. On imem_ack: instr<=imem_rdata, instr_pc<=pc_q, pc_inc=1 same cycle; next VALID.
- VALID: instr_valid=1, br_ready=1.
  - br_valid: pc_load=1, pc_din=br_target, instr discarded (no count); next REQ. Has priority over instr_ready and halt in the same cycle.
  - else instr_ready: fetch_count+1; next HALTED if halt, else REQ.
  - else hold; instr, instr_pc stable.
- HALTED: halted=1, br_ready=1, no requests. br_valid: pc_load target, next REQ. halt deassertion alone does not resume.
- br_valid in INIT or REQ is ignored (br_ready=0); requester holds it until br_ready.
- pc_load and pc_inc never asserted in the same cycle; pc_din = br_target or RESET_VECTOR only when pc_load=1, else 0.
- reset_n low mid-transaction: abandon outstanding read at once; a late imem_ack in INIT is ignored.

## Timing
- reset_n rises at edge N: pc_load high in cycle N, pc_q = RESET_VECTOR and imem_req high from N+1.
- imem_ack at cycle k: instr_valid high from k+1, pc_q = instr_pc+1 from k+1.
- Accept at cycle j: imem_req high from j+1. With single-cycle ack memory: one instruction per 2 cycles.
- Redirect at cycle j: imem_req high from j+1 with imem_addr = br_target.
- All outputs except pc_reset, pc_load, pc_inc, pc_din, br_ready are registered.

## Configuration
- FETCH_TIMEOUT_EN defined: wait counter clears on REQ entry, increments each REQ cycle without imem_ack; at TIMEOUT_CYCLES consecutive wait cycles, fetch_err<=1 (sticky until reset), imem_req drops, next HALTED. Redirect from HALTED still works; fetch_err stays set.
- Not defined: no wait counter, fetch_err tied 0, REQ waits indefinitely.

## Test plan
- RESET_VECTOR=32'h100, release reset, ack 1 cycle after each req, instr_ready=1 -> imem_addr 32'h100, 32'h101, 32'h102; fetch_count=3 after third accept.
- Hold instr_ready=0 for 5 cycles in VALID -> instr, instr_pc stable, no new imem_req, pc_q unchanged.
- br_valid=1, br_target=32'h2000 together with instr_ready in VALID -> instruction dropped, fetch_count unchanged, next imem_addr 32'h2000.
- halt=1 with accept -> halted=1, imem_req stays 0 for 10 cycles; then br_valid target 32'h40 -> fetch resumes at 32'h40.
- reset_n low for 1 cycle while imem_req waiting -> outputs at reset values, fetch restarts at RESET_VECTOR.
- FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=8, imem_ack never asserted -> fetch_err=1 and halted=1 after 8 wait cycles.
